pipelined_comparator: RTL and testbench
=======================================

PIPELINED_COMPARATOR -- requirements
Module: pipelined_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal range 4..64).
REQ-002 The block SHALL have parameter DIGIT, default 4, meaning bits examined per compare cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port A, input, WIDTH bits: first operand, sampled on accept.
REQ-006 The block SHALL have port B, input, WIDTH bits: second operand, sampled on accept.
REQ-007 The block SHALL have port is_signed, input, 1 bit: 1 = two's-complement compare, 0 = unsigned; sampled on accept.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the operands are presented.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-010 The block SHALL have port R, output, 3 bits: registered result {G,E,L}, one-hot when out_valid=1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: R holds a new result.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port cycles, output, $clog2(WIDTH/DIGIT)+1 bits: the number of compare cycles used by the last result.

Function
REQ-014 The block SHALL implement FSM states IDLE, COMPARE and DONE.
REQ-015 The block SHALL drive in_ready=1 only in IDLE; an accept is in_valid & in_ready on a rising edge.
REQ-016 On accept, the block SHALL latch A, B and is_signed, set the digit index k to WIDTH/DIGIT-1, clear the cycle count and enter COMPARE.
REQ-017 When is_signed=1, the block SHALL invert the MSB of both latched operands before comparing; the operands are otherwise unmodified.
REQ-018 In each COMPARE cycle, the block SHALL compare digit k (bits k*DIGIT+DIGIT-1 down to k*DIGIT) of both operands, MSB digit first, and increment the cycle count.
REQ-019 On a digit mismatch, the block SHALL register R=100 (A>B) or R=001 (A<B) and enter DONE (early termination).
REQ-020 On equal digits with k=0, the block SHALL register R=010 and enter DONE; otherwise it SHALL decrement k and stay in COMPARE.
REQ-021 Latency SHALL be 1 to WIDTH/DIGIT compare cycles after accept; out_valid SHALL rise on the edge that ends the last compare cycle.
REQ-022 In DONE, the block SHALL hold out_valid=1 and R stable until out_ready=1, then return to IDLE with out_valid=0.
REQ-023 R and cycles SHALL hold the last result in IDLE until the next result is registered.
REQ-024 in_valid SHALL be ignored in COMPARE and DONE; there SHALL be no same-cycle accept in DONE (a new accept is possible at the earliest one cycle after the handshake).
REQ-025 A or B changing after accept SHALL have no effect on the result in progress.

Reset
REQ-026 When rst_n=0, the block SHALL immediately enter IDLE with R=000, out_valid=0, cycles=0 and the operand registers cleared.
REQ-027 On reset mid-operation (COMPARE or DONE), the block SHALL discard the result in progress and produce no out_valid after release.
REQ-028 After rst_n deasserts, the block SHALL drive in_ready=1 in the first cycle.

Structure
REQ-029 The shared package cmp_pkg SHALL hold the state enum and the result constants R_GT=100, R_EQ=010, R_LT=001 and R_NONE=000.
REQ-030 The block SHALL contain one sub-module, cmp_digit: a combinational DIGIT-wide compare with outputs gt and lt, instantiated once and fed by a muxed digit.

Verification (WIDTH=16, DIGIT=4)
REQ-031 The bench SHALL apply A=16'hFFFF, B=16'h0001, is_signed=0 -> R=100, cycles=1.
REQ-032 The bench SHALL apply the same operands with is_signed=1 -> R=001, cycles=1.
REQ-033 The bench SHALL apply A=B=16'hA5A5 -> R=010, cycles=4, and out_valid SHALL rise 4 cycles after accept.
REQ-034 The bench SHALL apply A=16'h1234, B=16'h1235 -> R=001, cycles=4; it SHALL hold out_ready=0 for 5 cycles with R stable and in_ready=0, then release it -> in_ready=1 on the next cycle.
REQ-035 The bench SHALL pulse rst_n low in the second COMPARE cycle of A=16'h0F00, B=16'h0E00 -> R=000, out_valid stays 0, in_ready=1 after release.
REQ-036 The bench SHALL change A and B on every cycle after the accept of A=16'h8000, B=16'h7FFF (unsigned) -> R=100 and cycles=1 unaffected.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the digit-serial comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Result encodings {G,E,L}
  localparam logic [2:0] R_GT   = 3'b100;
  localparam logic [2:0] R_EQ   = 3'b010;
  localparam logic [2:0] R_LT   = 3'b001;
  localparam logic [2:0] R_NONE = 3'b000;

endpackage

// File: rtl/cmp_digit.sv
// Combinational magnitude compare of one DIGIT-wide slice.
module cmp_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             gt,
  output logic             lt
);

  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/pipelined_comparator.sv
// Digit-serial magnitude comparator: scans operands MSB digit first and
// stops at the first differing digit; signed mode biases the sign bit.
module pipelined_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [WIDTH-1:0]                     A,
  input  logic [WIDTH-1:0]                     B,
  input  logic                                 is_signed,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [2:0]                           R,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [$clog2(WIDTH/DIGIT):0]         cycles
);

  localparam int unsigned ND = WIDTH / DIGIT;
  localparam int unsigned KW = (ND > 1) ? $clog2(ND) : 1;
  localparam int unsigned CW = $clog2(ND) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cycles_d;
  logic [2:0]       r_d;
  logic             out_valid_d, in_ready_d;
  logic [WIDTH-1:0] msb_mask;
  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_gt, dig_lt;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign msb_mask = {is_signed, {(WIDTH-1){1'b0}}};

  // Single digit comparator fed by the digit selected by k
  assign dig_a = a_q[k_q*DIGIT +: DIGIT];
  assign dig_b = b_q[k_q*DIGIT +: DIGIT];

  cmp_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (dig_a),
    .b  (dig_b),
    .gt (dig_gt),
    .lt (dig_lt)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    cycles_d    = cycles;
    r_d         = R;
    out_valid_d = 1'b0;
    in_ready_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = A ^ msb_mask;
          b_d     = B ^ msb_mask;
          k_d     = KW'(ND - 1);
          cnt_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        cnt_d = cnt_q + CW'(1);
        if (dig_gt) begin
          r_d      = R_GT;
          cycles_d = cnt_q + CW'(1);
          state_d  = DONE;
        end else if (dig_lt) begin
          r_d      = R_LT;
          cycles_d = cnt_q + CW'(1);
          state_d  = DONE;
        end else if (k_q == '0) begin
          r_d      = R_EQ;
          cycles_d = cnt_q + CW'(1);
          state_d  = DONE;
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      cnt_q     <= '0;
      cycles    <= '0;
      R         <= R_NONE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      k_q       <= k_d;
      cnt_q     <= cnt_d;
      cycles    <= cycles_d;
      R         <= r_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_pipelined_comparator.sv
// Randomized and directed bench for pipelined_comparator against an
// arithmetic reference model.
module tb_pipelined_comparator;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned ND    = WIDTH / DIGIT;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  A, B;
  logic              is_signed;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        R;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        cycles;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  pipelined_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .is_signed (is_signed),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer comparison in the requested number system
  function automatic logic [2:0] ref_r(input logic [15:0] a, input logic [15:0] b, input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return 3'b100;
      if ($signed(a) < $signed(b)) return 3'b001;
      return 3'b010;
    end
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return 3'b010;
  endfunction

  // Digits scanned = digits from the top down to the highest differing bit
  function automatic int ref_cycles(input logic [15:0] a, input logic [15:0] b);
    int h;
    h = -1;
    for (int i = 0; i < 16; i++) if (a[i] != b[i]) h = i;
    if (h < 0) return ND;
    return ND - (h / DIGIT);
  endfunction

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int hold, input bit scramble, input bit noise);
    logic [2:0] er;
    int ec, n, w;
    er = ref_r(a, b, s);
    ec = ref_cycles(a, b);
    w = 0;
    while (!in_ready && w < 10) begin step(); w++; end
    check_eq("in_ready_idle", 64'(in_ready), 64'd1);
    A = a; B = b; is_signed = s; in_valid = 1'b1;
    step();
    in_valid = noise;
    n = 0;
    while (!out_valid && n < 2 * ND) begin
      if (scramble) begin
        A = 16'($urandom); B = 16'($urandom); is_signed = 1'($urandom);
      end
      if (noise) in_valid = 1'($urandom);
      step();
      n++;
    end
    check_eq("latency", 64'(n), 64'(ec));
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("R", 64'(R), 64'(er));
    check_eq("cycles", 64'(cycles), 64'(ec));
    check_eq("in_ready_busy", 64'(in_ready), 64'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      step();
      check_eq("hold_R", 64'(R), 64'(er));
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    if (noise) in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq("post_valid", 64'(out_valid), 64'd0);
    check_eq("post_ready", 64'(in_ready), 64'd1);
    check_eq("post_R", 64'(R), 64'(er));
    check_eq("post_cycles", 64'(cycles), 64'(ec));
  endtask

  initial begin
    logic [15:0] ra, rb;
    int kind, d;
    rst_n = 1'b0; A = '0; B = '0; is_signed = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst_R", 64'(R), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_cycles", 64'(cycles), 64'd0);
    #4 rst_n = 1'b1;
    step();
    check_eq("rst_ready", 64'(in_ready), 64'd1);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b1, 0, 1'b0, 1'b0);
    run_op(16'hA5A5, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1235, 1'b0, 5, 1'b0, 1'b0);

    // Reset during the second compare cycle discards the operation
    A = 16'h0F00; B = 16'h0E00; is_signed = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_R", 64'(R), 64'd0);
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_cycles", 64'(cycles), 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("after_rst_valid", 64'(out_valid), 64'd0);
      check_eq("after_rst_ready", 64'(in_ready), 64'd1);
    end

    run_op(16'h8000, 16'h7FFF, 1'b0, 0, 1'b1, 1'b0);

    for (int t = 0; t < 300; t++) begin
      ra = 16'($urandom);
      kind = $urandom_range(0, 3);
      d = $urandom_range(0, ND - 1);
      case (kind)
        0: rb = 16'($urandom);
        1: rb = ra;
        2: rb = ra ^ (16'($urandom_range(1, 15)) << (d * DIGIT));
        default: rb = ra ^ 16'd1;
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2), 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
